fp_grs_normalizer: RTL and testbench
====================================

Name: fp_grs_normalizer

Overview:
- Multi-cycle normalizer that produces the rounder's inputs: 23-bit mantissa, guard/round/sticky, sign and exponent.
- Takes a wide unnormalized significand from the multiply/add datapath and shifts it into 1.x form, or into denormal form when the exponent underflows.
- Collapses all shifted-out bits into sticky.
- Sits between the arithmetic core and floating_point_rounder, with a valid/ready handshake on both sides.

Parameters:
- SIG_W, 48, input significand width; hidden-bit position is SIG_W-2, bit SIG_W-1 is carry-out.
- EXP_W, 10, signed two's-complement biased exponent width.
- STEP, 4, maximum shift distance per cycle, left or right; must be at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block idle, can accept an operand
- in_sig  in  SIG_W  unnormalized significand
- in_exp  in  EXP_W  signed biased exponent aligned to hidden bit SIG_W-2
- in_sign  in  1  sign, passed through
- in_rm  in  3  rounding mode, passed through
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_mantissa  out  23  fraction bits SIG_W-3 down to SIG_W-25
- out_guard, out_round, out_sticky  out  1 each  GRS bits for the rounder
- out_exp  out  EXP_W  result exponent; 0 when denormal or zero
- out_sign  out  1  registered in_sign
- out_rm  out  3  registered in_rm
- out_denorm  out  1  result is subnormal
- out_zero  out  1  input significand was zero

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset state: state=IDLE; all outputs and internal registers 0, except in_ready=1 once rst_n is high.
- Reset asserted mid-operation aborts the operation immediately; no output is produced for it.
- Internal registers: sig (SIG_W bits), exp (EXP_W bits), sticky_acc.
- FSM states: IDLE, NORM, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: capture sig, exp, sign and rm; clear sticky_acc; go to NORM.
- NORM, one decision per cycle, checked in this priority order:
  1. sig==0: go to OUT with zero=1.
  2. sig[SIG_W-1]=1: shift right 1, exp+1, OR the shifted-out bit into sticky_acc.
  3. exp<1: shift right by n=min(STEP, 1-exp), exp+n, OR all shifted-out bits into sticky_acc.
  4. sig[SIG_W-2]=0 and exp>1: shift left by n=min(STEP, leading zeros below bit SIG_W-1, exp-1), exp-n.
  5. Otherwise: go to OUT.
- Right shifts that empty sig end in the zero check on the next cycle. Outputs are then mantissa 0, GRS 0, sticky=sticky_acc, out_zero=0, out_denorm=1.
- Entering OUT registers the outputs:
  - mantissa = sig[SIG_W-3 -: 23]
  - guard = sig[SIG_W-26]
  - round = sig[SIG_W-27]
  - sticky = OR of sig[SIG_W-28:0] OR sticky_acc
  - denorm = sig[SIG_W-2]==0 and not zero
  - out_exp = 0 if denorm or zero, else exp
- OUT:
  - out_valid=1; outputs held stable until out_ready.
  - On out_ready: go to IDLE and drop out_valid.
  - in_ready=0 in NORM and in OUT; there is no overlap of operations.
- Latency: from accept cycle to first out_valid = 2 + number of shifting NORM cycles.
- No exponent-overflow detection here; out_exp may exceed 254. Overflow is handled after the rounder.
- in_exp is interpreted as signed; bits beyond EXP_W never wrap because shifts are bounded by exp-1 and 1-exp.

Optional Feature:
- Macro: FP_GRS_NORM_FASTPATH_EN.
- Defined: in IDLE, an input with in_sig[SIG_W-1:SIG_W-2]==2'b01 and in_exp>=1 goes directly to OUT with outputs computed from the inputs. Latency is 1; all other inputs behave as without the macro.
- Undefined: every operation passes through NORM, minimum latency 2.

Test Plan:
1. in_sig=48'h4000_0000_0000, in_exp=127, out_ready=1 -> mantissa 0, G=R=S=0, out_exp=127, denorm=0, out_valid 2 cycles after accept (1 with FASTPATH).
2. in_sig=48'h8000_0000_0001, in_exp=127 -> one right shift, out_exp=128, mantissa 0, G=R=0, sticky=1, latency 3.
3. in_sig=48'h0000_0040_0000 (bit 22), in_exp=127 -> 24-bit left normalization in 6 shift cycles, out_exp=103, mantissa 0, GRS 0, latency 8.
4. in_sig=48'h4000_0000_0000, in_exp=-2 -> right shift 3 in one cycle, mantissa=23'h100000, out_denorm=1, out_exp=0, GRS 0, latency 3. Also in_sig=48'h0000_0000_0001, in_exp=1 -> mantissa 0, sticky=1, denorm=1.
5. in_sig=0, in_exp=50, in_sign=1, in_rm=3 -> out_zero=1, out_exp=0, mantissa 0, GRS 0, out_sign=1, out_rm=3, latency 2.
6. Hold out_ready=0 for 5 cycles after out_valid -> all outputs stable, in_ready=0, a second in_valid is ignored. Then assert rst_n=0 during NORM of a new operation -> out_valid=0 immediately, in_ready=1 after release, no stale output.

Source files
------------

// File: rtl/fp_grs_normalizer.sv
// fp_grs_normalizer: multi-cycle significand normalizer feeding floating_point_rounder.
// Shifts a wide significand into 1.x form, or into denormal form when the exponent
// underflows. Bits shifted out on the right are folded into a sticky accumulator.
// Optional build macro FP_GRS_NORM_FASTPATH_EN: already-normalized operands with a
// positive exponent bypass the NORM state and complete in one cycle.
module fp_grs_normalizer #(
    parameter int SIG_W = 48,
    parameter int EXP_W = 10,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] in_sig,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sign,
    input  logic [2:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [22:0]      out_mantissa,
    output logic             out_guard,
    output logic             out_round,
    output logic             out_sticky,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic [2:0]       out_rm,
    output logic             out_denorm,
    output logic             out_zero
);

    // Width of a per-cycle shift amount (0..STEP).
    localparam int SH_W = $clog2(STEP + 1);
    localparam logic [SH_W-1:0]    STEP_S = SH_W'(STEP);
    // Exponent arithmetic is done one bit wider so 1-exp never overflows.
    localparam logic signed [EXP_W:0] STEP_E = (EXP_W+1)'(STEP);
    localparam logic signed [EXP_W:0] ONE_E  = (EXP_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Everything the rounder sees, registered together on entry to OUT.
    typedef struct packed {
        logic [22:0]      mant;
        logic             guard;
        logic             round;
        logic             sticky;
        logic [EXP_W-1:0] exp;
        logic             denorm;
        logic             zero;
    } res_t;

    state_t                  state_reg, state_next;
    logic [SIG_W-1:0]        sig_reg, sig_next;
    logic signed [EXP_W-1:0] exp_reg, exp_next;
    logic                    acc_reg, acc_next;
    logic                    sign_reg, sign_next;
    logic [2:0]              rm_reg, rm_next;
    res_t                    res_reg, res_next;

    // Shift-planning signals for the current NORM cycle.
    logic [STEP-1:0]         lead_hit;
    logic [SH_W-1:0]         lz_cap;
    logic signed [EXP_W:0]   exp_ext;
    logic signed [EXP_W:0]   rdist;
    logic signed [EXP_W:0]   ldist;
    logic [SH_W-1:0]         ldist_cap;
    logic [SH_W-1:0]         n_right;
    logic [SH_W-1:0]         n_left;
    logic [SIG_W-1:0]        sig_shr;
    logic [SIG_W-1:0]        sig_shl;
    logic                    shr_lost;

    // Derive the rounder-facing fields from a normalized (or denormal) significand.
    // A significand emptied by right shifts still carries sticky, so it is not "zero".
    function automatic res_t pack_result(input logic [SIG_W-1:0] s,
                                         input logic acc,
                                         input logic [EXP_W-1:0] e);
        res_t res;
        res.zero   = (s == '0) && !acc;
        res.mant   = s[SIG_W-3 -: 23];
        res.guard  = s[SIG_W-26];
        res.round  = s[SIG_W-27];
        res.sticky = (|s[SIG_W-28:0]) | acc;
        res.denorm = !s[SIG_W-2] && !res.zero;
        res.exp    = (res.denorm || res.zero) ? '0 : e;
        return res;
    endfunction

    // Bits just below the carry position, used to count leading zeros up to STEP.
    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_lead
            assign lead_hit[gi] = sig_reg[SIG_W-2-gi];
        end
    endgenerate

    // Leading-zero count below the carry bit, saturated at STEP.
    always_comb begin
        lz_cap = STEP_S;
        for (int k = STEP - 1; k >= 0; k--) begin
            if (lead_hit[k]) lz_cap = SH_W'(k);
        end
    end

    // Per-cycle shift distances and the shifted significands.
    always_comb begin
        exp_ext   = {exp_reg[EXP_W-1], exp_reg};
        rdist     = ONE_E - exp_ext;
        ldist     = exp_ext - ONE_E;
        n_right   = (rdist > STEP_E) ? STEP_S : SH_W'(rdist);
        ldist_cap = (ldist > STEP_E) ? STEP_S : SH_W'(ldist);
        n_left    = (ldist_cap < lz_cap) ? ldist_cap : lz_cap;
        sig_shr   = sig_reg >> n_right;
        shr_lost  = |(sig_reg & ~({SIG_W{1'b1}} << n_right));
        sig_shl   = sig_reg << n_left;
    end

    // FSM next-state and datapath next-values.
    always_comb begin
        state_next = state_reg;
        sig_next   = sig_reg;
        exp_next   = exp_reg;
        acc_next   = acc_reg;
        sign_next  = sign_reg;
        rm_next    = rm_reg;
        res_next   = res_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sig_next   = in_sig;
                    exp_next   = in_exp;
                    acc_next   = 1'b0;
                    sign_next  = in_sign;
                    rm_next    = in_rm;
                    state_next = NORM;
`ifdef FP_GRS_NORM_FASTPATH_EN
                    // Already 01.x with exp >= 1: nothing to shift, finish now.
                    if (in_sig[SIG_W-1:SIG_W-2] == 2'b01 &&
                        !in_exp[EXP_W-1] && in_exp != '0) begin
                        res_next   = pack_result(in_sig, 1'b0, in_exp);
                        state_next = OUT;
                    end
`endif
                end
            end
            NORM: begin
                if (sig_reg == '0) begin
                    res_next   = pack_result(sig_reg, acc_reg, exp_reg);
                    state_next = OUT;
                end else if (sig_reg[SIG_W-1]) begin
                    sig_next = sig_reg >> 1;
                    exp_next = exp_reg + EXP_W'(1);
                    acc_next = acc_reg | sig_reg[0];
                end else if (exp_ext < ONE_E) begin
                    sig_next = sig_shr;
                    exp_next = exp_reg + EXP_W'(n_right);
                    acc_next = acc_reg | shr_lost;
                end else if (!sig_reg[SIG_W-2] && exp_ext > ONE_E) begin
                    sig_next = sig_shl;
                    exp_next = exp_reg - EXP_W'(n_left);
                end else begin
                    res_next   = pack_result(sig_reg, acc_reg, exp_reg);
                    state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Working and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_reg  <= '0;
            exp_reg  <= '0;
            acc_reg  <= 1'b0;
            sign_reg <= 1'b0;
            rm_reg   <= '0;
            res_reg  <= '0;
        end else begin
            sig_reg  <= sig_next;
            exp_reg  <= exp_next;
            acc_reg  <= acc_next;
            sign_reg <= sign_next;
            rm_reg   <= rm_next;
            res_reg  <= res_next;
        end
    end

    assign in_ready     = rst_n && (state_reg == IDLE);
    assign out_valid    = (state_reg == OUT);
    assign out_mantissa = res_reg.mant;
    assign out_guard    = res_reg.guard;
    assign out_round    = res_reg.round;
    assign out_sticky   = res_reg.sticky;
    assign out_exp      = res_reg.exp;
    assign out_denorm   = res_reg.denorm;
    assign out_zero     = res_reg.zero;
    assign out_sign     = sign_reg;
    assign out_rm       = rm_reg;

endmodule

// File: tb/tb_fp_grs_normalizer.sv
// Testbench for fp_grs_normalizer: directed cases plus random operands checked
// against a closed-form normalization model (MSB position and exponent algebra).
module tb_fp_grs_normalizer;

    localparam int SIG_W = 48;
    localparam int EXP_W = 10;
    localparam int STEP  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SIG_W-1:0] in_sig = '0;
    logic [EXP_W-1:0] in_exp = '0;
    logic             in_sign = 1'b0;
    logic [2:0]       in_rm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [22:0]      out_mantissa;
    logic             out_guard, out_round, out_sticky;
    logic [EXP_W-1:0] out_exp;
    logic             out_sign;
    logic [2:0]       out_rm;
    logic             out_denorm, out_zero;

    int checks = 0;
    int errors = 0;
    int ops = 0;

    fp_grs_normalizer #(.SIG_W(SIG_W), .EXP_W(EXP_W), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sig(in_sig), .in_exp(in_exp), .in_sign(in_sign), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mantissa(out_mantissa), .out_guard(out_guard), .out_round(out_round),
        .out_sticky(out_sticky), .out_exp(out_exp), .out_sign(out_sign),
        .out_rm(out_rm), .out_denorm(out_denorm), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0]      mant;
        logic             g;
        logic             r;
        logic             s;
        logic [EXP_W-1:0] e;
        logic             dn;
        logic             z;
        int               lat;
    } ref_t;

    task automatic chk(input string tag, input string fld,
                       input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    function automatic int cdiv(input int a);
        return (a + STEP - 1) / STEP;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Value-level model: normal result puts the MSB at bit 46 with exponent
    // e + (msb - 46); if that is below 1 the value is re-expressed at exponent 1.
    function automatic ref_t model(input logic [47:0] s, input int e);
        ref_t x;
        int p, en, sh, r, cyc;
        logic [47:0] f;
        logic lost;
        x.mant = '0; x.g = 0; x.r = 0; x.s = 0; x.e = '0; x.dn = 0; x.z = 0; x.lat = 2;
        if (s == '0) begin
            x.z = 1;
            return x;
        end
        p = 0;
        for (int i = 0; i < 48; i++) if (s[i]) p = i;
        en = e + p - 46;
        lost = 0;
        f = s;
        if (en >= 1) begin
            if (p == 47) begin
                lost = s[0];
                f = s >> 1;
            end else begin
                f = s << (46 - p);
            end
            x.e = EXP_W'(en);
        end else begin
            sh = e - 1;
            if (sh >= 0) begin
                f = s << sh;
            end else begin
                r = -sh;
                if (r >= 48) begin
                    f = '0;
                    lost = 1;
                end else begin
                    f = s >> r;
                    lost = |(s & ((48'h1 << r) - 48'h1));
                end
            end
            x.dn = 1;
        end
        x.mant = f[45:23];
        x.g    = f[22];
        x.r    = f[21];
        x.s    = (|f[20:0]) | lost;
        // Shift cycles: right shifts stop at exponent 1 or when the value empties.
        if (p == 47) begin
            if (e + 1 >= 1) cyc = 1;
            else cyc = 1 + imin(cdiv(1 - (e + 1)), cdiv(47));
        end else if (e < 1) begin
            cyc = imin(cdiv(1 - e), cdiv(p + 1));
        end else if (p == 46 || e == 1) begin
            cyc = 0;
        end else begin
            cyc = cdiv(imin(46 - p, e - 1));
        end
        x.lat = 2 + cyc;
`ifdef FP_GRS_NORM_FASTPATH_EN
        if (p == 46 && e >= 1) x.lat = 1;
`endif
        return x;
    endfunction

    task automatic check_result(input string tag, input ref_t x,
                                input logic sg, input logic [2:0] rm);
        chk(tag, "mant",   out_mantissa, x.mant);
        chk(tag, "guard",  out_guard,    x.g);
        chk(tag, "round",  out_round,    x.r);
        chk(tag, "sticky", out_sticky,   x.s);
        chk(tag, "exp",    out_exp,      x.e);
        chk(tag, "denorm", out_denorm,   x.dn);
        chk(tag, "zero",   out_zero,     x.z);
        chk(tag, "sign",   out_sign,     sg);
        chk(tag, "rm",     out_rm,       rm);
    endtask

    // One operation: launch, measure latency, check, optionally stall, then accept.
    task automatic do_op(input string tag, input logic [47:0] s, input int e,
                         input logic sg, input logic [2:0] rm, input int hold);
        ref_t x;
        int lat, w;
        x = model(s, e);
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk(tag, "in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_sig = s; in_exp = EXP_W'(e); in_sign = sg; in_rm = rm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sig = {$urandom, $urandom};
        in_exp = EXP_W'($urandom);
        in_sign = ~sg;
        in_rm = ~rm;
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        chk(tag, "latency", lat, x.lat);
        check_result(tag, x, sg, rm);
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk(tag, "hold_valid", out_valid, 1'b1);
            chk(tag, "hold_ready", in_ready, 1'b0);
            chk(tag, "hold_mant", out_mantissa, x.mant);
            chk(tag, "hold_exp", out_exp, x.e);
            chk(tag, "hold_sticky", out_sticky, x.s);
        end
        in_valid = 1'b0;
        $display("op %0d %s sig=%012h exp=%0d lat=%0d mant=%06h grs=%b%b%b oexp=%0d dn=%b z=%b",
                 ops, tag, s, e, lat, out_mantissa, out_guard, out_round, out_sticky,
                 out_exp, out_denorm, out_zero);
        ops++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk(tag, "drop_valid", out_valid, 1'b0);
        chk(tag, "back_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [63:0] r64;
        logic [47:0] rs;
        int m, re;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "out_valid", out_valid, 1'b0);
        chk("reset", "in_ready_low", in_ready, 1'b0);
        chk("reset", "mant", out_mantissa, 23'h0);
        chk("reset", "exp", out_exp, '0);
        chk("reset", "sticky", out_sticky, 1'b0);
        chk("reset", "zero", out_zero, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("reset", "in_ready_high", in_ready, 1'b1);

        // Directed cases.
        do_op("normal",    48'h4000_0000_0000, 127, 1'b0, 3'd0, 0);
        do_op("carry",     48'h8000_0000_0001, 127, 1'b1, 3'd1, 0);
        do_op("left24",    48'h0000_0040_0000, 127, 1'b0, 3'd2, 0);
        do_op("denorm3",   48'h4000_0000_0000, -2,  1'b0, 3'd4, 0);
        do_op("denorm_lsb",48'h0000_0000_0001, 1,   1'b0, 3'd0, 0);
        do_op("zero",      48'h0,              50,  1'b1, 3'd3, 0);
        do_op("empty",     48'h0000_0000_0001, -100,1'b0, 3'd1, 0);
        do_op("left_clip", 48'h0000_0000_0100, 5,   1'b1, 3'd2, 0);
        do_op("carry_dn",  48'hC000_0000_0003, -5,  1'b0, 3'd0, 0);
        do_op("min_exp",   48'h7FFF_FFFF_FFFF, -512,1'b0, 3'd0, 0);

        // Stall with out_ready low; extra in_valid must be ignored.
        do_op("hold", 48'h5A5A_5A5A_5A5A, 100, 1'b1, 3'd5, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("hold", "no_ghost_valid", out_valid, 1'b0);
        chk("hold", "idle_ready", in_ready, 1'b1);

        // Reset during NORM aborts the operation.
        in_valid = 1'b1; in_sig = 48'h0000_0040_0000; in_exp = EXP_W'(127);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort", "valid_low", out_valid, 1'b0);
        chk("abort", "ready_in_reset", in_ready, 1'b0);
        chk("abort", "mant", out_mantissa, 23'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort", "ready_after", in_ready, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("abort", "no_stale", out_valid, 1'b0);
        do_op("post_abort", 48'h2000_0000_0000, 10, 1'b0, 3'd6, 0);

        // Random operands.
        for (int n = 0; n < 60; n++) begin
            r64 = {$urandom, $urandom};
            m = $urandom_range(0, 47);
            rs = r64[47:0] >> (47 - m);
            rs[m] = 1'b1;
            if ($urandom_range(0, 9) == 0) rs = '0;
            re = int'($urandom_range(0, 300)) - 130;
            do_op("rand", rs, re, 1'($urandom), 3'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
